// File: rtl/uart_pkg.sv
// Shared UART TX definitions: default FIFO depth, baud divisor width, byte type.
package uart_pkg;
   localparam int TX_FIFO_DEPTH = 16;
   localparam int BAUD_DIV_W    = 16;

   typedef logic [7:0] byte_t;
endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one-clock baud_pulse every `divisor` clocks, idle when divisor is 0.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int DIV_W = BAUD_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] divisor,
   output logic             baud_pulse
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             run_q, run_d;

   // run_q marks a loaded count, so a zero count right after reset is not mistaken for a tick.
   always_comb begin
      cnt_d = cnt_q;
      run_d = run_q;
      if (divisor == '0) begin
         cnt_d = '0;
         run_d = 1'b0;
      end else if (!run_q || (cnt_q == '0)) begin
         cnt_d = divisor - 1'b1;
         run_d = 1'b1;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign baud_pulse = run_q && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit control: baud generator plus TX byte queue feeding the TX core.
// Macro UART_TX_FIFO_EN selects a DEPTH-entry FIFO; otherwise a single holding register.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH = TX_FIFO_DEPTH,
   parameter int DIV_W = BAUD_DIV_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DIV_W-1:0]       divisor,
   input  logic                   fifo_en,
   input  logic                   tx_fifo_rst,
   input  logic                   wr_en,
   input  logic [7:0]             wr_data,
   input  logic                   pop,
   input  logic                   sreg_empty,
   output logic                   baud_pulse,
   output logic                   thre,
   output logic [7:0]             din,
   output logic                   temt,
   output logic [$clog2(DEPTH):0] tx_level,
   output logic                   wr_ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [LW-1:0] level_q, level_d, cap;
   logic          flush, do_pop, do_wr, ovf_d, ovf_q;
   byte_t         head;

   uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
      .clk        (clk),
      .rst        (rst),
      .divisor    (divisor),
      .baud_pulse (baud_pulse)
   );

`ifdef UART_TX_FIFO_EN
   byte_t         mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic          fen_q;

   // A mode switch invalidates queued bytes, so it flushes like tx_fifo_rst.
   assign cap   = fifo_en ? LW'(DEPTH) : LW'(1);
   assign flush = tx_fifo_rst || (fifo_en != fen_q);
   assign head  = mem_q[rptr_q];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (do_wr)  wptr_d = wptr_q + 1'b1;
         if (do_pop) rptr_d = rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         fen_q  <= fifo_en;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         fen_q  <= fifo_en;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wptr_q] <= wr_data;
   end
`else
   byte_t hold_q;
   logic  unused_fifo_en;

   assign unused_fifo_en = fifo_en;
   assign cap            = LW'(1);
   assign flush          = tx_fifo_rst;
   assign head           = hold_q;

   always_ff @(posedge clk) begin
      if (do_wr) hold_q <= wr_data;
   end
`endif

   // A pop in the same cycle frees the slot, so a write at capacity still lands.
   assign do_pop = pop && (level_q != '0) && !flush;
   assign do_wr  = wr_en && !flush && ((level_q < cap) || do_pop);
   assign ovf_d  = wr_en && !flush && !do_wr;

   always_comb begin
      level_d = level_q + LW'(do_wr) - LW'(do_pop);
      if (flush) level_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         level_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         level_q <= level_d;
         ovf_q   <= ovf_d;
      end
   end

   assign tx_level = level_q;
   assign thre     = (level_q == '0);
   assign din      = thre ? 8'h00 : head;
   assign temt     = thre && sreg_empty;
   assign wr_ovf   = ovf_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl against a queue-based reference model.
module tb_uart_tx_ctrl;

   localparam int DEPTH = 16;
   localparam int DIV_W = 16;
`ifdef UART_TX_FIFO_EN
   localparam bit FB = 1'b1;
`else
   localparam bit FB = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [DIV_W-1:0] divisor;
   logic             fifo_en, tx_fifo_rst, wr_en, pop, sreg_empty;
   logic [7:0]       wr_data;
   logic             baud_pulse, thre, temt, wr_ovf;
   logic [7:0]       din;
   logic [4:0]       tx_level;

   uart_tx_ctrl #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .divisor     (divisor),
      .fifo_en     (fifo_en),
      .tx_fifo_rst (tx_fifo_rst),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .pop         (pop),
      .sreg_empty  (sreg_empty),
      .baud_pulse  (baud_pulse),
      .thre        (thre),
      .din         (din),
      .temt        (temt),
      .tx_level    (tx_level),
      .wr_ovf      (wr_ovf)
   );

   always #5 clk = ~clk;

   int         n_chk  = 0;
   int         n_fail = 0;
   logic [7:0] q[$];
   bit         m_ovf;
   bit         prev_fen;
   int         bn;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic cyc(input bit r, input bit w, input logic [7:0] d, input bit p,
                      input bit f, input bit fen, input bit se);
      int cap;
      rst = r; wr_en = w; wr_data = d; pop = p;
      tx_fifo_rst = f; fifo_en = fen; sreg_empty = se;
      cap = (FB && fen) ? DEPTH : 1;
      if (!r) begin
         q.delete();
         m_ovf    = 1'b0;
         bn       = 0;
         prev_fen = fen;
      end else begin
         bn    = (divisor == 0) ? 0 : bn + 1;
         m_ovf = 1'b0;
         if (f || (FB && (fen != prev_fen))) begin
            q.delete();
         end else begin
            if (p && q.size() > 0) void'(q.pop_front());
            if (w) begin
               if (q.size() < cap) q.push_back(d);
               else m_ovf = 1'b1;
            end
         end
         prev_fen = fen;
      end
      @(posedge clk);
      #1;
      chk("tx_level", 32'(tx_level), 32'(q.size()));
      chk("thre", 32'(thre), 32'(q.size() == 0));
      chk("din", 32'(din), (q.size() == 0) ? 32'h0 : 32'(q[0]));
      chk("wr_ovf", 32'(wr_ovf), 32'(m_ovf));
      chk("temt", 32'(temt), 32'((q.size() == 0) && se));
      chk("baud_pulse", 32'(baud_pulse),
          32'((divisor != 0) && (bn > 0) && ((bn % divisor) == 0)));
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; divisor = 16'd6; fifo_en = 1'b1; tx_fifo_rst = 1'b0;
      wr_en = 1'b0; wr_data = 8'h00; pop = 1'b0; sreg_empty = 1'b1;
      @(negedge clk);

      // reset held with a write attempted, then idle baud timing
      repeat (3) cyc(0, 1, 8'h55, 0, 0, 1, 1);
      repeat (14) cyc(1, 0, 8'h00, 0, 0, 1, 1'($urandom_range(0, 1)));

      // two writes then two pops
      cyc(1, 1, 8'h13, 0, 0, 1, 0);
      cyc(1, 1, 8'hA5, 0, 0, 1, 0);
      cyc(1, 0, 8'h00, 1, 0, 1, 0);
      cyc(1, 0, 8'h00, 1, 0, 1, 1);

      // overfill, write+pop at full, drain, write+pop when empty
      for (int i = 0; i < 17; i++) cyc(1, 1, 8'($urandom), 0, 0, 1, 0);
      cyc(1, 1, 8'($urandom), 1, 0, 1, 0);
      for (int i = 0; i < 16; i++) cyc(1, 0, 8'h00, 1, 0, 1, 0);
      cyc(1, 1, 8'($urandom), 1, 0, 1, 0);
      cyc(1, 0, 8'h00, 1, 0, 1, 1);

      // flush with a same-cycle write
      for (int i = 0; i < 5; i++) cyc(1, 1, 8'($urandom), 0, 0, 1, 0);
      cyc(1, 1, 8'($urandom), 0, 1, 1, 1);

      // holding-register mode, overflow, reset mid-queue
      cyc(1, 0, 8'h00, 0, 0, 0, 0);
      cyc(1, 1, 8'h3C, 0, 0, 0, 0);
      cyc(1, 1, 8'hC3, 0, 0, 0, 0);
      cyc(0, 0, 8'h00, 0, 0, 0, 1);
      cyc(1, 0, 8'h00, 0, 0, 0, 1);
      cyc(1, 0, 8'h00, 0, 0, 1, 1);

      // random traffic with occasional flushes and mode switches
      for (int i = 0; i < 300; i++) begin
         bit fen;
         fen = fifo_en;
         if ($urandom_range(0, 39) == 0) fen = ~fen;
         cyc(1, 1'($urandom_range(0, 9) < 6), 8'($urandom), 1'($urandom_range(0, 9) < 4),
             1'($urandom_range(0, 31) == 0), fen, 1'($urandom_range(0, 1)));
      end

      // baud generator disabled, then re-enabled
      divisor = 16'd0;
      repeat (8) cyc(1, 0, 8'h00, 0, 0, fifo_en, 1);
      divisor = 16'd6;
      repeat (14) cyc(1, 0, 8'h00, 0, 0, fifo_en, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16: transmit FIFO depth in bytes (power of two, >=2).
REQ-002 SHALL have parameter DIV_W, default 16: baud divisor width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous reset, active-low (0 = reset).
REQ-005 SHALL have port divisor, input, DIV_W: clocks per baud_pulse; 0 disables the baud generator.
REQ-006 SHALL have port fifo_en, input, 1: 1 = FIFO mode (DEPTH entries); 0 = single holding register.
REQ-007 SHALL have port tx_fifo_rst, input, 1: one-cycle flush request.
REQ-008 SHALL have port wr_en, input, 1 and port wr_data, input, 8: host byte write.
REQ-009 SHALL have port pop, input, 1 and port sreg_empty, input, 1: TX core consumed head byte; TX core shift register idle.
REQ-010 SHALL have port baud_pulse, output, 1: one-clock baud tick to the TX core.
REQ-011 SHALL have port thre, output, 1 and port din, output, 8: 1 = no byte available; head byte to the TX core.
REQ-012 SHALL have port temt, output, 1: FIFO empty and sreg_empty high.
REQ-013 SHALL have port tx_level, output, $clog2(DEPTH)+1: current byte count.
REQ-014 SHALL have port wr_ovf, output, 1: one-clock pulse when a write is dropped.

Function
REQ-015 Baud counter SHALL load divisor-1, decrement each clock, assert baud_pulse for exactly one clock at 0, then reload; period = divisor clocks.
REQ-016 divisor==0 SHALL hold baud_pulse low and the counter at 0; a divisor change SHALL take effect at the next reload.
REQ-017 thre SHALL equal (tx_level==0), combinationally from registered state; din SHALL be the head entry, 8'h00 when empty.
REQ-018 Capacity SHALL be DEPTH when fifo_en=1 and 1 when fifo_en=0.
REQ-019 wr_en with tx_level<capacity SHALL store wr_data at the tail; tx_level increments next cycle.
REQ-020 wr_en at capacity with no pop SHALL drop the byte and pulse wr_ovf next cycle; contents unchanged.
REQ-021 pop with tx_level>0 SHALL advance the read pointer; pop when empty SHALL be ignored.
REQ-022 Simultaneous wr_en and pop at capacity SHALL do both, with no wr_ovf; level unchanged.
REQ-023 Simultaneous wr_en and pop when empty SHALL ignore pop and accept the write; level = 1.
REQ-024 Pointers SHALL wrap modulo DEPTH; tx_level SHALL never exceed DEPTH.
REQ-025 tx_fifo_rst, or any change of fifo_en, SHALL flush: level 0 next cycle, with priority over a same-cycle wr_en or pop (both lost, no wr_ovf); the baud counter SHALL be unaffected.
REQ-026 temt SHALL be (tx_level==0) && sreg_empty.

Reset
REQ-027 rst=0 at a clock edge SHALL clear pointers, tx_level, and the baud counter, and SHALL give baud_pulse=0, wr_ovf=0, thre=1, din=8'h00; temt then follows sreg_empty.
REQ-028 Reset asserted mid-operation SHALL discard queued bytes; the first baud_pulse after release SHALL occur divisor clocks after the first unreset edge.

Configuration
REQ-029 Macro UART_TX_FIFO_EN defined: behaviour as REQ-018.
REQ-030 UART_TX_FIFO_EN undefined: no FIFO storage; capacity fixed at 1; fifo_en ignored (no flush on change); tx_level width unchanged, values 0..1.

Structure
REQ-031 Package uart_pkg SHALL hold the TX FIFO depth default, the divisor width default, and the byte typedef (8 bits).
REQ-032 The baud generator SHALL be sub-module uart_baud_gen (clk, rst, divisor, baud_pulse); FIFO logic SHALL stay in uart_tx_ctrl.

Verification
REQ-033 divisor=6 after reset -> baud_pulse high 1 clock every 6 clocks, first pulse on the 6th clock after reset release.
REQ-034 fifo_en=1: write 8'h13, 8'hA5 -> thre falls 1 clock after the first write, din=8'h13; pop -> din=8'hA5; pop -> thre=1, tx_level=0.
REQ-035 fifo_en=1: 17 consecutive writes, no pops -> tx_level=16, one wr_ovf pulse, 17th byte absent; 16 pops return bytes in write order.
REQ-036 tx_level=16: wr_en and pop in the same cycle -> tx_level stays 16, no wr_ovf; empty FIFO with wr_en and pop -> tx_level=1.
REQ-037 tx_level=5, tx_fifo_rst with wr_en in the same cycle -> tx_level=0, thre=1, no wr_ovf; with sreg_empty=1 -> temt=1.
REQ-038 fifo_en=0: two writes -> second is dropped with a wr_ovf pulse; rst=0 mid-queue -> thre=1, tx_level=0 next cycle.
